// File: rtl/axi_rd_burst_engine_pkg.sv
// Shared AXI constants and engine FSM encoding for the iDMA read/write engines.
package idma_axi_pkg;
   localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
   localparam logic [1:0]  AXI_RESP_OKAY  = 2'b00;
   localparam int unsigned PAGE_BYTES     = 4096;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      ISSUE,
      DRAIN
   } eng_state_e;
endpackage

// File: rtl/axi_rd_burst_engine_if.sv
// Descriptor, AR, R, rdata-FIFO and status signals of the iDMA AXI read engine.
interface axi_rd_burst_engine_if #(
   parameter int AXI_IDW      = 4,
   parameter int AXI_LOCKW    = 2,
   parameter int AXI_DATA_WID = 256,
   parameter int AXI_STRBW    = AXI_DATA_WID / 8,
   parameter int AXI_LENW     = 8
);
   logic                    desc_valid;
   logic                    desc_ready;
   logic [31:0]             desc_addr;
   logic [31:0]             desc_num_word;
   logic [3:0]              cfg_outstd;
   logic                    cfg_cross4k_en;
   logic                    o_arvalid;
   logic [AXI_IDW-1:0]      o_arid;
   logic [31:0]             o_araddr;
   logic [AXI_LENW-1:0]     o_arlen;
   logic [2:0]              o_arsize;
   logic [1:0]              o_arburst;
   logic [AXI_LOCKW-1:0]    o_arlock;
   logic [3:0]              o_arcache;
   logic [2:0]              o_arprot;
   logic                    i_arready;
   logic                    i_rvalid;
   logic [AXI_DATA_WID-1:0] i_rdata;
   logic [AXI_IDW-1:0]      i_rid;
   logic [1:0]              i_rresp;
   logic                    i_rlast;
   logic                    o_rready;
   logic                    rdata_fifo_full;
   logic                    rdata_fifo_push;
   logic [AXI_DATA_WID-1:0] rdata_fifo_data;
   logic [AXI_STRBW-1:0]    rdata_fifo_strb;
   logic                    rd_err;
   logic                    read_all_done;

   modport master (
      input  desc_valid, desc_addr, desc_num_word, cfg_outstd, cfg_cross4k_en,
      input  i_arready, i_rvalid, i_rdata, i_rid, i_rresp, i_rlast, rdata_fifo_full,
      output desc_ready, o_arvalid, o_arid, o_araddr, o_arlen, o_arsize, o_arburst,
      output o_arlock, o_arcache, o_arprot, o_rready,
      output rdata_fifo_push, rdata_fifo_data, rdata_fifo_strb, rd_err, read_all_done
   );

   modport slave (
      output desc_valid, desc_addr, desc_num_word, cfg_outstd, cfg_cross4k_en,
      output i_arready, i_rvalid, i_rdata, i_rid, i_rresp, i_rlast, rdata_fifo_full,
      input  desc_ready, o_arvalid, o_arid, o_araddr, o_arlen, o_arsize, o_arburst,
      input  o_arlock, o_arcache, o_arprot, o_rready,
      input  rdata_fifo_push, rdata_fifo_data, rdata_fifo_strb, rd_err, read_all_done
   );
endinterface

// File: rtl/axi_rd_burst_engine_len_calc.sv
// Burst length for the next AR: min(remaining beats, MAX_BURST, beats left in the 4 KB page).
module axi_burst_len_calc
   import idma_axi_pkg::*;
#(
   parameter int AXI_STRBW = 32,
   parameter int MAX_BURST = 16
) (
   input  logic [31:0] addr_i,
   input  logic [31:0] rem_i,
   input  logic        cross4k_en_i,
   output logic [31:0] blen_o
);
   localparam int OFFW = $clog2(AXI_STRBW);

   logic [31:0] page_beats;
   logic [31:0] cap;
   logic [19:0] unused_addr_hi;

   assign unused_addr_hi = addr_i[31:12];

   // addr_i is beat aligned, so the page remainder divides exactly.
   always_comb begin
      page_beats = (32'(PAGE_BYTES) - {20'd0, addr_i[11:0]}) >> OFFW;
      cap        = (rem_i > 32'(MAX_BURST)) ? 32'(MAX_BURST) : rem_i;
      blen_o     = (cross4k_en_i && (cap > page_beats)) ? page_beats : cap;
   end
endmodule

// File: rtl/axi_rd_burst_engine.sv
// iDMA AXI read engine: splits one descriptor into AR bursts and streams R beats to the rdata FIFO.
module axi_rd_burst_engine
   import idma_axi_pkg::*;
#(
   parameter int                 AXI_IDW      = 4,
   parameter int                 AXI_LOCKW    = 2,
   parameter int                 AXI_DATA_WID = 256,
   parameter int                 AXI_STRBW    = AXI_DATA_WID / 8,
   parameter int                 AXI_LENW     = 8,
   parameter int                 MAX_BURST    = 16,
   parameter int                 MAX_OUTSTD   = 8,
   parameter logic [AXI_IDW-1:0] ID           = '0
) (
   input logic                   aclk,
   input logic                   areset,
   axi_rd_burst_engine_if.master bus
);
   localparam int OFFW = $clog2(AXI_STRBW);
   localparam int OUTW = $clog2(MAX_OUTSTD + 1);

   eng_state_e         state_q, state_d;
   logic [31:0]        addr_q, addr_d, rem_q, rem_d, blen_q, blen_d, blen_calc;
   logic [OUTW-1:0]    outstd_q, outstd_d, lim;
   logic [31:0]        lim_c;
   logic               rd_err_q, rd_err_d, done_q, done_d;
   logic               arvalid, ar_hs, rready, r_hs, rlast_hs, in_issue;
   logic [AXI_IDW-1:0] unused_rid;

   assign unused_rid = bus.i_rid;

   axi_burst_len_calc #(
      .AXI_STRBW (AXI_STRBW),
      .MAX_BURST (MAX_BURST)
   ) u_len_calc (
      .addr_i       (addr_q),
      .rem_i        (rem_q),
      .cross4k_en_i (bus.cfg_cross4k_en),
      .blen_o       (blen_calc)
   );

   always_comb begin
      lim_c = {28'd0, bus.cfg_outstd};
      if (lim_c == 32'd0) lim_c = 32'd1;
      if (lim_c > 32'(MAX_OUTSTD)) lim_c = 32'(MAX_OUTSTD);
      lim = OUTW'(lim_c);
   end

   // R path: ready only while a burst is in flight, so stale beats after reset are refused.
   assign rready   = !bus.rdata_fifo_full && (outstd_q != '0);
   assign r_hs     = bus.i_rvalid && rready;
   assign rlast_hs = r_hs && bus.i_rlast;
   assign ar_hs    = arvalid && bus.i_arready;
   assign outstd_d = outstd_q + OUTW'(ar_hs) - OUTW'(rlast_hs);

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      rem_d    = rem_q;
      blen_d   = blen_q;
      rd_err_d = rd_err_q;
      done_d   = 1'b0;
      arvalid  = 1'b0;
      if (r_hs && (bus.i_rresp != AXI_RESP_OKAY)) rd_err_d = 1'b1;
      case (state_q)
         IDLE: begin
            if (bus.desc_valid) begin
               addr_d   = bus.desc_addr & ~32'(AXI_STRBW - 1);
               rem_d    = bus.desc_num_word;
               rd_err_d = 1'b0;
               state_d  = (bus.desc_num_word == 32'd0) ? DRAIN : CALC;
            end
         end
         CALC: begin
            blen_d  = blen_calc;
            state_d = ISSUE;
         end
         ISSUE: begin
            // Only R completions change outstd_q here, so arvalid cannot drop before arready.
            arvalid = (outstd_q < lim);
            if (arvalid && bus.i_arready) begin
               addr_d  = addr_q + (blen_q << OFFW);
               rem_d   = rem_q - blen_q;
               state_d = (rem_q == blen_q) ? DRAIN : CALC;
            end
         end
         DRAIN: begin
            if (outstd_q == '0) begin
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         state_q  <= IDLE;
         outstd_q <= '0;
         rd_err_q <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         outstd_q <= outstd_d;
         rd_err_q <= rd_err_d;
         done_q   <= done_d;
      end
   end

   always_ff @(posedge aclk) begin
      addr_q <= addr_d;
      rem_q  <= rem_d;
      blen_q <= blen_d;
   end

   assign in_issue            = (state_q == ISSUE);
   assign bus.desc_ready      = (state_q == IDLE);
   assign bus.o_arvalid       = arvalid;
   assign bus.o_arid          = in_issue ? ID : '0;
   assign bus.o_araddr        = in_issue ? addr_q : '0;
   assign bus.o_arlen         = in_issue ? AXI_LENW'(blen_q - 32'd1) : '0;
   assign bus.o_arsize        = in_issue ? 3'(OFFW) : '0;
   assign bus.o_arburst       = in_issue ? AXI_BURST_INCR : '0;
   assign bus.o_arlock        = '0;
   assign bus.o_arcache       = '0;
   assign bus.o_arprot        = '0;
   assign bus.o_rready        = rready;
   assign bus.rdata_fifo_push = r_hs;
   assign bus.rdata_fifo_data = r_hs ? bus.i_rdata : '0;
   assign bus.rdata_fifo_strb = r_hs ? '1 : '0;
   assign bus.rd_err          = rd_err_q;
   assign bus.read_all_done   = done_q;
endmodule

// File: doc/axi_rd_burst_engine.md
Name: axi_rd_burst_engine

Overview:
Parametrised next-generation iDMA AXI read engine. It accepts one read descriptor (start address, beat count) and splits it into AXI bursts. Each burst is limited by a configurable maximum length and by 4 KB boundaries. The engine issues AR requests under a programmable outstanding limit and streams R beats into the downstream rdata FIFO with backpressure. Unlike the previous generation, it has a parametrised data width, an AXI3/AXI4 length width, a parametrised outstanding depth, a descriptor valid/ready handshake, and sticky error capture.

Parameters:
- AXI_IDW, 4, width of the ARID and RID fields.
- AXI_LOCKW, 2, width of ARLOCK.
- AXI_DATA_WID, 256, width of the R data bus; a power of 2, 32..1024.
- AXI_STRBW, AXI_DATA_WID/8, strobe width; also the number of bytes per beat.
- AXI_LENW, 8, width of ARLEN (4 = AXI3, 8 = AXI4).
- MAX_BURST, 16, maximum beats per burst; must be ≤ 2^AXI_LENW.
- MAX_OUTSTD, 8, hard cap on outstanding bursts; sets the width of the outstanding counter.
- ID, 0, constant value driven on ARID.

Ports:
- aclk  in  1  clock.
- areset  in  1  reset; synchronous, active-high.
- desc_valid  in  1  descriptor offered.
- desc_ready  out  1  engine can accept a descriptor (high only in IDLE).
- desc_addr  in  32  start byte address.
- desc_num_word  in  32  number of beats to read.
- cfg_outstd  in  4  outstanding limit.
- cfg_cross4k_en  in  1  enable splitting at 4 KB boundaries.
- o_arvalid  out  1  AR valid.
- o_arid  out  AXI_IDW  AR ID.
- o_araddr  out  32  AR address.
- o_arlen  out  AXI_LENW  AR length.
- o_arsize  out  3  AR size.
- o_arburst  out  2  AR burst type.
- o_arlock  out  AXI_LOCKW  AR lock.
- o_arcache  out  4  AR cache.
- o_arprot  out  3  AR protection.
- i_arready  in  1  AR ready.
- i_rvalid  in  1  R valid.
- i_rdata  in  AXI_DATA_WID  R data.
- i_rid  in  AXI_IDW  R ID.
- i_rresp  in  2  R response.
- i_rlast  in  1  R last.
- o_rready  out  1  R ready.
- rdata_fifo_full  in  1  downstream FIFO full.
- rdata_fifo_push  out  1  push one beat into the FIFO.
- rdata_fifo_data  out  AXI_DATA_WID  beat data.
- rdata_fifo_strb  out  AXI_STRBW  beat strobes.
- rd_err  out  1  sticky error flag.
- read_all_done  out  1  one-cycle completion pulse.

Behaviour:
- **Reset values:** all outputs 0 except desc_ready = 1. The FSM goes to IDLE and all counters clear.
- **Reset mid-operation:** the current descriptor is abandoned. Late R beats are not accepted, because o_rready is gated by outstanding != 0.

FSM, states IDLE, CALC, ISSUE, DRAIN:
- **IDLE:** desc_valid & desc_ready latches the descriptor and goes to CALC.
  - The address is latched with the low log2(AXI_STRBW) bits forced to 0.
  - The beat count is latched as rem = desc_num_word.
  - rd_err is cleared.
- **IDLE, zero-length descriptor:** if desc_num_word == 0, go directly to DRAIN. No AR is issued; read_all_done pulses the next cycle.
- **CALC (1 cycle):** blen = min(rem, MAX_BURST, beats to the 4 KB boundary). The boundary term applies only if cfg_cross4k_en, and equals (4096 − addr[11:0]) / AXI_STRBW. Then go to ISSUE.
- **ISSUE:** o_arvalid is asserted when outstanding < lim, where lim = min(max(cfg_outstd, 1), MAX_OUTSTD).
  - o_araddr = addr, o_arlen = blen − 1, o_arsize = log2(AXI_STRBW), o_arburst = INCR, o_arlock, o_arcache and o_arprot = 0, o_arid = ID.
  - Once asserted, o_arvalid and all AR fields stay stable until i_arready.
  - On handshake: addr += blen × AXI_STRBW and rem −= blen. Go to DRAIN if rem == 0, otherwise to CALC.
- **DRAIN:** when outstanding == 0, pulse read_all_done for 1 cycle and return to IDLE. desc_ready rises in the same cycle.

Outstanding counter:
- +1 on AR handshake; −1 on an R handshake with i_rlast.
- If both occur in the same cycle, the count is unchanged.
- It never exceeds MAX_OUTSTD.

R path:
- o_rready = !rdata_fifo_full & (outstanding != 0).
- rdata_fifo_push = i_rvalid & o_rready. The push is combinational (zero latency); data is i_rdata and strb is all ones.

Errors:
- An R handshake with i_rresp != 0 sets rd_err. It stays set until the next descriptor is accepted.
- Beats with errors are still pushed into the FIFO.

Arithmetic:
- The address adder is 32-bit and wraps modulo 2^32. Wrap beyond 4 GB is not an error condition.
- The 4 KB split guarantees no burst crosses a 4 KB page when cfg_cross4k_en = 1.

Decomposition:
- **Package idma_axi_pkg:** AXI_BURST_INCR = 2'b01, AXI_RESP_OKAY = 2'b00, PAGE_BYTES = 4096, and the FSM state enum (IDLE, CALC, ISSUE, DRAIN).
- **Sub-module axi_burst_len_calc:** combinational. Inputs are addr, rem, cfg_cross4k_en and the parameters; output is blen. Reused by the future write engine.
- The outstanding counter, FSM and R path stay in the top module.

Test Plan:
1. **4 KB split:** AXI_DATA_WID = 256, addr 0x0FC0, num_word 8, cfg_cross4k_en = 1 → bursts (0x0FC0, len 1) and (0x1000, len 5); read_all_done after the 8th beat.
2. **Outstanding limit:** addr 0, num_word 64, MAX_BURST 16, cfg_outstd = 2, R held off → exactly 2 AR handshakes, then o_arvalid stays low until the first rlast, then the 3rd AR issues.
3. **Backpressure and AR stability:** rdata_fifo_full toggles every other cycle → o_rready follows it; no beat is lost; pushes total num_word. With i_arready delayed 5 cycles, the AR fields stay unchanged.
4. **Zero-length descriptor and error capture:** num_word = 0 → no o_arvalid, read_all_done one cycle after acceptance. Then a descriptor with one beat returning rresp = 2 → rd_err = 1 and the beat is still pushed. The next descriptor accept clears rd_err.
5. **Simultaneous events and reset:** AR handshake and rlast in the same cycle → outstanding unchanged. Assert areset mid-burst → all outputs at reset values next cycle, desc_ready = 1, o_rready = 0.
